// File: rtl/riscv_instr_pkg.sv
// Shared fetch-stage types: queued entry layout, FSM states, canonical NOP, and a
// saturating add used by the optional performance counters.
package riscv_instr_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  fault;
  } fetch_entry_t;

  function automatic logic [31:0] perf_sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w_sum;
    w_sum = {1'b0, a} + {1'b0, b};
    return w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
  endfunction

endpackage

// File: rtl/rickv_fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module rickv_fetch_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Pointer and occupancy update; flush empties the queue and drops any push
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  rickv_fetch_fifo_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush),
    .i_push  (i_push),
    .i_pop   (w_do_pop),
    .i_full  (w_full)
  );

endmodule

// Overflow checker: the credit scheme upstream must never push into a full queue.
module rickv_fetch_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic i_flush,
  input logic i_push,
  input logic i_pop,
  input logic i_full
);

  // Flags a push that would overwrite a live entry
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush) begin
      assert (!(i_push && i_full && !i_pop)) else $error("rickv_fetch_fifo overflow");
    end
  end

endmodule

// File: rtl/rickv_fetch_unit.sv
// Instruction fetch stage: pipelined word requests, in-order entry queue, redirect flush.
// Optional macro RICKV_FETCH_PERF_EN adds saturating perf_fetched/perf_stall/perf_flushed.
import riscv_instr_pkg::*;

module rickv_fetch_unit #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef RICKV_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int            EW        = XLEN + 33;
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   w_inflight_nxt;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_drop_nxt;
  logic            r_mis_pend;
  logic [XLEN-1:0] r_mis_pc;

  logic            w_credit_ok;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_live;
  logic            w_pop;
  logic            w_ent_push;
  logic [EW-1:0]   w_ent_wdata;
  logic [EW-1:0]   w_head;
  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_tag_head;
  logic [CW-1:0]   w_tag_count_unused;

  // Every outstanding request holds a queue slot, so the queue can never overflow
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_count}) < DEPTH_LIM;
  assign w_req_valid = rst_n && (r_state == FETCH_RUN) && !r_mis_pend &&
                       !redirect_valid && w_credit_ok;
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_rsp_live  = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid && !r_mis_pend;
  assign w_pop       = out_valid && out_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;

  // FSM next state: redirect restarts, a queued fault halts fetching
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = FETCH_RUN;
    end else if (r_mis_pend) begin
      w_state_nxt = FETCH_HALT;
    end else if (w_rsp_live && imem_rsp_err) begin
      w_state_nxt = FETCH_HALT;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FETCH_RUN;
    else        r_state <= w_state_nxt;
  end

  // PC, in-flight and stale-response bookkeeping
  always_comb begin
    w_pc_nxt       = r_pc;
    w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
    w_drop_nxt     = r_drop_cnt;
    if (redirect_valid) begin
      w_pc_nxt   = redirect_pc;
      w_drop_nxt = r_inflight - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) w_pc_nxt = r_pc + XLEN'(4);
      else            w_pc_nxt = r_pc;
      if (imem_rsp_valid && (r_drop_cnt != '0)) w_drop_nxt = r_drop_cnt - CW'(1);
      else                                      w_drop_nxt = r_drop_cnt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_mis_pend <= 1'b0;
      r_mis_pc   <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_mis_pend <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      r_mis_pc   <= redirect_valid ? redirect_pc : r_mis_pc;
    end
  end

  // Entry queue write: misaligned-redirect fault or a live memory response
  always_comb begin
    w_ent_push  = 1'b0;
    w_ent_wdata = '0;
    if (redirect_valid) begin
      w_ent_push = 1'b0;
    end else if (r_mis_pend) begin
      w_ent_push  = 1'b1;
      w_ent_wdata = {r_mis_pc, INSTR_NOP, 1'b1};
    end else if (w_rsp_live) begin
      w_ent_push  = 1'b1;
      w_ent_wdata = {w_tag_head, (imem_rsp_err ? INSTR_NOP : imem_rsp_data), imem_rsp_err};
    end else begin
      w_ent_push = 1'b0;
    end
  end

  rickv_fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_entry_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_ent_push),
    .i_wdata (w_ent_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  rickv_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_req_fire),
    .i_wdata (r_pc),
    .i_pop   (w_rsp_live),
    .o_rdata (w_tag_head),
    .o_count (w_tag_count_unused)
  );

  assign out_valid = (w_count != '0);
  assign out_pc    = out_valid ? w_head[EW-1:33] : '0;
  assign out_instr = out_valid ? w_head[32:1]    : 32'h0000_0000;
  assign out_fault = out_valid ? w_head[0]       : 1'b0;

`ifdef RICKV_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flushed;
  logic [31:0] w_flush_inc;

  assign w_flush_inc = 32'(redirect_valid ? (w_count - CW'(w_pop)) : CW'(0)) +
                       32'(imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0)));

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0000_0000;
      r_perf_stall   <= 32'h0000_0000;
      r_perf_flushed <= 32'h0000_0000;
    end else begin
      r_perf_fetched <= perf_sat_add(r_perf_fetched, 32'(w_pop));
      r_perf_stall   <= perf_sat_add(r_perf_stall, 32'(!out_valid && !redirect_valid));
      r_perf_flushed <= perf_sat_add(r_perf_flushed, w_flush_inc);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule
